// File: rtl/set_cfg.sv
// set_cfg: slow-peripheral settings register with a staged shadow copy.
//
// Software stages a value into a shadow register and then commits it to the
// active outputs in one step. Writes to the shadow/active pair are protected
// by a two-word key unlock sequence. An unlocked block that stays idle for
// UNLK_TO cycles relocks by itself and discards any staged value.
//
// Build option:
//   SETCFG_LOCK_EN  defined   : key FSM and idle relock are present.
//                   undefined : the block is permanently unlocked. KEY
//                               writes are ignored and Unlocked is tied to 1.
//
// Ports:
//   CLK          system clock
//   POR          synchronous active-high reset
//   BACT         bus access active
//   SetCSWR      settings chip-select with write
//   Op[1:0]      0=KEY, 1=STAGE, 2=COMMIT, 3=REVERT
//   A[DW:1]      write data: A[NCH:1] enables, A[DW:NCH+1] timeout
//   SlowEn       active slow-enable bits
//   SlowTimeout  active slow-access timeout
//   Unlocked     block is accepting STAGE/COMMIT/REVERT
//   Pending      shadow differs from active
//   CommitPulse  one-cycle pulse after each commit
module set_cfg #(
  parameter int              NCH     = 7,
  parameter int              TOW     = 4,
  parameter int              DW      = TOW + NCH,
  parameter logic [NCH-1:0]  RST_EN  = 7'h32,
  parameter logic [TOW-1:0]  RST_TO  = 4'hF,
  parameter logic [DW-1:0]   KEY     = 11'h5A5,
  parameter int              UNLK_TO = 255
) (
  input  logic           CLK,
  input  logic           POR,
  input  logic           BACT,
  input  logic           SetCSWR,
  input  logic [1:0]     Op,
  input  logic [DW:1]    A,
  output logic [NCH-1:0] SlowEn,
  output logic [TOW-1:0] SlowTimeout,
  output logic           Unlocked,
  output logic           Pending,
  output logic           CommitPulse
);

  typedef enum logic [1:0] {
    OP_KEY    = 2'd0,
    OP_STAGE  = 2'd1,
    OP_COMMIT = 2'd2,
    OP_REVERT = 2'd3
  } op_t;

  localparam logic [DW-1:0] RST_VAL = {RST_TO, RST_EN};

  // Bus write capture. wrQ/opQ/dQ are sampled on every edge, including
  // during reset, so a strobe held across reset is already "seen" when reset
  // releases; together with wrD resetting to 1 this suppresses a spurious
  // event until the strobe drops and reasserts.
  logic          wrQ;
  logic          wrD;
  op_t           opQ;
  logic [DW-1:0] dQ;
  logic          ev;

  logic [DW-1:0] shadow;
  logic [DW-1:0] active;
  logic          commitQ;

  assign ev = wrQ && !wrD;

`ifdef SETCFG_LOCK_EN
  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2
  } state_t;

  localparam int            CW        = $clog2(UNLK_TO + 1);
  localparam logic [CW-1:0] TO_RELOAD = CW'(UNLK_TO);
  localparam logic [DW-1:0] KEY2      = ~KEY;

  state_t        state;
  logic [CW-1:0] idleCnt;
`else
  assign Unlocked = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    wrQ <= BACT && SetCSWR;
    opQ <= op_t'(Op);
    dQ  <= A;

    if (POR) begin
      wrD         <= 1'b1;
      shadow      <= RST_VAL;
      active      <= RST_VAL;
      commitQ     <= 1'b0;
      SlowEn      <= RST_EN;
      SlowTimeout <= RST_TO;
      Pending     <= 1'b0;
      CommitPulse <= 1'b0;
`ifdef SETCFG_LOCK_EN
      state       <= LOCKED;
      idleCnt     <= '0;
      Unlocked    <= 1'b0;
`endif
    end else begin
      wrD     <= wrQ;
      commitQ <= 1'b0;

`ifdef SETCFG_LOCK_EN
      if (ev) begin
        case (state)
          LOCKED: begin
            if (opQ == OP_KEY && dQ == KEY) state <= KEY1;
          end
          KEY1: begin
            if (opQ == OP_KEY && dQ == KEY2) begin
              state   <= UNLOCKED;
              idleCnt <= TO_RELOAD;
            end else begin
              state <= LOCKED;
            end
          end
          UNLOCKED: begin
            case (opQ)
              OP_STAGE: begin
                shadow  <= dQ;
                idleCnt <= TO_RELOAD;
              end
              OP_COMMIT: begin
                active  <= shadow;
                commitQ <= 1'b1;
                state   <= LOCKED;
              end
              OP_REVERT: begin
                shadow <= active;
                state  <= LOCKED;
              end
              default: state <= LOCKED;
            endcase
          end
          default: state <= LOCKED;
        endcase
      end else if (state == UNLOCKED) begin
        // Relock on the idle cycle that takes the counter to zero, so exactly
        // UNLK_TO idle cycles follow the last reload.
        if (idleCnt <= CW'(1)) begin
          shadow <= active;
          state  <= LOCKED;
        end else begin
          idleCnt <= idleCnt - CW'(1);
        end
      end
      Unlocked <= (state == UNLOCKED);
`else
      if (ev) begin
        case (opQ)
          OP_STAGE:  shadow <= dQ;
          OP_COMMIT: begin
            active  <= shadow;
            commitQ <= 1'b1;
          end
          OP_REVERT: shadow <= active;
          default:   ;
        endcase
      end
`endif

      // All visible outputs are registered copies of the internal state.
      SlowEn      <= active[NCH-1:0];
      SlowTimeout <= active[DW-1:NCH];
      Pending     <= (shadow != active);
      CommitPulse <= commitQ;
    end
  end

endmodule

// File: tb/tb_set_cfg.sv
// Self-checking bench for set_cfg. Works for both builds: the reference model
// follows SETCFG_LOCK_EN the same way the design does.
module tb_set_cfg;

  localparam int          NCH     = 7;
  localparam int          TOW     = 4;
  localparam int          DW      = 11;
  localparam int          UNLK_TO = 255;
  localparam logic [10:0] KEYW    = 11'h5A5;
  localparam logic [10:0] KEYN    = 11'h25A;
  localparam logic [10:0] RSTV    = {4'hF, 7'h32};
`ifdef SETCFG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          POR = 1'b1;
  logic          BACT = 1'b0;
  logic          SetCSWR = 1'b0;
  logic [1:0]    Op = 2'd0;
  logic [DW:1]   A = '0;
  logic [NCH-1:0] SlowEn;
  logic [TOW-1:0] SlowTimeout;
  logic          Unlocked;
  logic          Pending;
  logic          CommitPulse;

  int nCmp = 0;
  int nErr = 0;

  // Reference model: lock progress (0 = locked, 1 = first key seen,
  // 2 = open), shadow and active settings words, and commits performed.
  int          mLvl;
  logic [10:0] mShadow;
  logic [10:0] mActive;
  int          mCommits = 0;

  // Observed commit pulses.
  int pulseCnt = 0;
  bit adjPulse = 1'b0;
  bit prevPulse = 1'b0;

  set_cfg #(
    .NCH(NCH),
    .TOW(TOW),
    .DW(DW),
    .RST_EN(7'h32),
    .RST_TO(4'hF),
    .KEY(KEYW),
    .UNLK_TO(UNLK_TO)
  ) dut (
    .CLK(CLK),
    .POR(POR),
    .BACT(BACT),
    .SetCSWR(SetCSWR),
    .Op(Op),
    .A(A),
    .SlowEn(SlowEn),
    .SlowTimeout(SlowTimeout),
    .Unlocked(Unlocked),
    .Pending(Pending),
    .CommitPulse(CommitPulse)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (CommitPulse === 1'b1) begin
      pulseCnt++;
      if (prevPulse) adjPulse = 1'b1;
    end
    prevPulse = (CommitPulse === 1'b1);
  end

  function automatic void mReset();
    mLvl    = 0;
    mShadow = RSTV;
    mActive = RSTV;
  endfunction

  function automatic void mWrite(input logic [1:0] op, input logic [10:0] d);
    if (!LOCK || mLvl == 2) begin
      case (op)
        2'd1: mShadow = d;
        2'd2: begin mActive = mShadow; mCommits++; end
        2'd3: mShadow = mActive;
        default: ;
      endcase
      if (LOCK && op != 2'd1) mLvl = 0;
    end else if (mLvl == 0) begin
      mLvl = (op == 2'd0 && d == KEYW) ? 1 : 0;
    end else begin
      mLvl = (op == 2'd0 && d == KEYN) ? 2 : 0;
    end
  endfunction

  function automatic logic mUnl();
    return !LOCK || mLvl == 2;
  endfunction

  // One bus write: strobe held for 'hold' sampled edges, then idle.
  task automatic wr(input logic [1:0] op, input logic [10:0] d,
                    input int unsigned hold, input int unsigned gap);
    @(posedge CLK); #1;
    Op = op; A = d; BACT = 1'b1; SetCSWR = 1'b1;
    repeat (hold) @(posedge CLK);
    #1;
    BACT = 1'b0; SetCSWR = 1'b0;
    Op = 2'($urandom); A = 11'($urandom);
    mWrite(op, d);
    repeat (gap) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic doReset();
    @(posedge CLK); #1;
    POR = 1'b1; BACT = 1'b0; SetCSWR = 1'b0;
    repeat (2) @(posedge CLK);
    #1 POR = 1'b0;
    mReset();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    doReset();
    nCmp++;
    if ({SlowTimeout, SlowEn, Unlocked, Pending, CommitPulse} !==
        {4'hF, 7'h32, !LOCK, 1'b0, 1'b0}) begin
      nErr++;
      $display("FAIL reset: got to=%h en=%h unl=%b pend=%b cp=%b, expected to=f en=32 unl=%b pend=0 cp=0",
               SlowTimeout, SlowEn, Unlocked, Pending, CommitPulse, !LOCK);
    end
  endtask

  task automatic test_full_sequence();
    int c0;
    wr(2'd0, KEYW, 1, 3);
    wr(2'd0, KEYN, 1, 3);
    nCmp++;
    if (Unlocked !== 1'b1) begin
      nErr++; $display("FAIL full_unlock: got unl=%b, expected 1", Unlocked);
    end
    wr(2'd1, 11'h3C1, 1, 3);
    nCmp++;
    if (Pending !== 1'b1) begin
      nErr++; $display("FAIL full_stage_pending: got pend=%b, expected 1", Pending);
    end
    c0 = pulseCnt;
    // COMMIT strobe sampled at edge k; outputs must move at k+2, not k+1.
    @(posedge CLK); #1;
    Op = 2'd2; A = '0; BACT = 1'b1; SetCSWR = 1'b1;
    @(posedge CLK); #1;
    BACT = 1'b0; SetCSWR = 1'b0;
    mWrite(2'd2, 11'h000);
    @(posedge CLK);
    @(negedge CLK);
    nCmp++;
    if ({SlowTimeout, SlowEn, CommitPulse} !== {4'hF, 7'h32, 1'b0}) begin
      nErr++;
      $display("FAIL full_commit_k1: got to=%h en=%h cp=%b, expected to=f en=32 cp=0",
               SlowTimeout, SlowEn, CommitPulse);
    end
    @(posedge CLK);
    @(negedge CLK);
    nCmp++;
    if ({SlowTimeout, SlowEn, CommitPulse} !== {4'h7, 7'h41, 1'b1}) begin
      nErr++;
      $display("FAIL full_commit_k2: got to=%h en=%h cp=%b, expected to=7 en=41 cp=1",
               SlowTimeout, SlowEn, CommitPulse);
    end
    @(negedge CLK);
    nCmp++;
    if ({CommitPulse, Unlocked, Pending} !== {1'b0, !LOCK, 1'b0} || pulseCnt - c0 != 1) begin
      nErr++;
      $display("FAIL full_after: got cp=%b unl=%b pend=%b pulses=%0d, expected cp=0 unl=%b pend=0 pulses=1",
               CommitPulse, Unlocked, Pending, pulseCnt - c0, !LOCK);
    end
  endtask

  task automatic test_bad_key();
    wr(2'd0, KEYW, 1, 3);
    wr(2'd0, KEYW, 1, 3);
    wr(2'd1, 11'h000, 1, 3);
    nCmp++;
    if ({SlowTimeout, SlowEn, Unlocked, Pending} !== {mActive, mUnl(), mShadow != mActive}) begin
      nErr++;
      $display("FAIL bad_key_stage: got to=%h en=%h unl=%b pend=%b, expected to=%h en=%h unl=%b pend=%b",
               SlowTimeout, SlowEn, Unlocked, Pending, mActive[10:7], mActive[6:0], mUnl(), mShadow != mActive);
    end
    wr(2'd0, KEYN, 1, 3);
    nCmp++;
    if ({Unlocked, Pending} !== {mUnl(), mShadow != mActive}) begin
      nErr++;
      $display("FAIL bad_key_second: got unl=%b pend=%b, expected unl=%b pend=%b",
               Unlocked, Pending, mUnl(), mShadow != mActive);
    end
  endtask

  task automatic test_idle_relock();
    doReset();
    wr(2'd0, KEYW, 1, 3);
    wr(2'd0, KEYN, 1, 3);
    @(posedge CLK); #1;
    Op = 2'd1; A = '0; BACT = 1'b1; SetCSWR = 1'b1;
    @(posedge CLK); #1;
    BACT = 1'b0; SetCSWR = 1'b0;
    mWrite(2'd1, 11'h000);
    repeat (UNLK_TO + 1) @(posedge CLK);
    @(negedge CLK);
    nCmp++;
    if ({Unlocked, Pending} !== {mUnl(), 1'b1}) begin
      nErr++;
      $display("FAIL idle_before_expiry: got unl=%b pend=%b, expected unl=%b pend=1",
               Unlocked, Pending, mUnl());
    end
    @(posedge CLK);
    @(negedge CLK);
    if (LOCK && mLvl == 2) begin mShadow = mActive; mLvl = 0; end
    nCmp++;
    if ({SlowTimeout, SlowEn, Unlocked, Pending} !== {mActive, mUnl(), mShadow != mActive}) begin
      nErr++;
      $display("FAIL idle_expired: got to=%h en=%h unl=%b pend=%b, expected to=%h en=%h unl=%b pend=%b",
               SlowTimeout, SlowEn, Unlocked, Pending, mActive[10:7], mActive[6:0], mUnl(), mShadow != mActive);
    end
    if (!LOCK) wr(2'd3, 11'h000, 1, 3);
  endtask

  task automatic test_held_strobe();
    int c0;
    wr(2'd0, KEYW, 20, 3);
    nCmp++;
    if (Unlocked !== mUnl()) begin
      nErr++; $display("FAIL held_key1: got unl=%b, expected %b", Unlocked, mUnl());
    end
    wr(2'd0, KEYN, 1, 3);
    nCmp++;
    if (Unlocked !== 1'b1) begin
      nErr++; $display("FAIL held_unlock: got unl=%b, expected 1", Unlocked);
    end
    wr(2'd1, 11'($urandom), 1, 3);
    c0 = pulseCnt;
    wr(2'd2, 11'h000, 20, 3);
    nCmp++;
    if (pulseCnt - c0 != 1) begin
      nErr++; $display("FAIL held_commit_pulses: got %0d, expected 1", pulseCnt - c0);
    end
    nCmp++;
    if ({SlowTimeout, SlowEn, Unlocked, Pending} !== {mActive, mUnl(), mShadow != mActive}) begin
      nErr++;
      $display("FAIL held_commit_out: got to=%h en=%h unl=%b pend=%b, expected to=%h en=%h unl=%b pend=%b",
               SlowTimeout, SlowEn, Unlocked, Pending, mActive[10:7], mActive[6:0], mUnl(), mShadow != mActive);
    end
  endtask

  task automatic test_reset_mid();
    wr(2'd0, KEYW, 1, 3);
    wr(2'd0, KEYN, 1, 3);
    wr(2'd1, 11'($urandom), 1, 3);
    @(posedge CLK); #1;
    POR = 1'b1;
    Op = LOCK ? 2'd0 : 2'd1;
    A = LOCK ? KEYW : 11'h000;
    BACT = 1'b1; SetCSWR = 1'b1;
    repeat (3) @(posedge CLK);
    #1 POR = 1'b0;
    mReset();
    repeat (3) @(posedge CLK);
    #1 BACT = 1'b0; SetCSWR = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nCmp++;
    if ({SlowTimeout, SlowEn, Unlocked, Pending} !== {RSTV, !LOCK, 1'b0}) begin
      nErr++;
      $display("FAIL reset_mid_defaults: got to=%h en=%h unl=%b pend=%b, expected to=f en=32 unl=%b pend=0",
               SlowTimeout, SlowEn, Unlocked, Pending, !LOCK);
    end
    wr(2'd0, KEYN, 1, 3);
    nCmp++;
    if ({Unlocked, Pending} !== {mUnl(), mShadow != mActive}) begin
      nErr++;
      $display("FAIL reset_mid_no_event: got unl=%b pend=%b, expected unl=%b pend=%b",
               Unlocked, Pending, mUnl(), mShadow != mActive);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [10:0] d;
    int unsigned r;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      op = 2'd0;
      d = 11'($urandom);
      if (r < 25)      d = (mLvl == 1) ? KEYN : KEYW;
      else if (r < 30) d = 11'($urandom);
      else if (r < 55) op = 2'd1;
      else if (r < 70) op = 2'd2;
      else if (r < 80) op = 2'd3;
      else if (r < 90) op = 2'($urandom);
      else             d = KEYN;
      if (r >= 80 && r < 90) begin
        // Only one of the two qualifiers: never a write.
        @(posedge CLK); #1;
        Op = op; A = d;
        if (r[0]) BACT = 1'b1; else SetCSWR = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1 BACT = 1'b0; SetCSWR = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
      end else begin
        wr(op, d, $urandom_range(1, 4), $urandom_range(3, 5));
      end
      nCmp++;
      if ({SlowTimeout, SlowEn, Unlocked, Pending} !== {mActive, mUnl(), mShadow != mActive}) begin
        nErr++;
        $display("FAIL rand[%0d] op=%0d d=%h: got to=%h en=%h unl=%b pend=%b, expected to=%h en=%h unl=%b pend=%b",
                 i, op, d, SlowTimeout, SlowEn, Unlocked, Pending,
                 mActive[10:7], mActive[6:0], mUnl(), mShadow != mActive);
      end
      nCmp++;
      if (pulseCnt != mCommits) begin
        nErr++;
        $display("FAIL rand_pulses[%0d]: got %0d, expected %0d", i, pulseCnt, mCommits);
      end
    end
    nCmp++;
    if (adjPulse !== 1'b0) begin
      nErr++; $display("FAIL pulse_width: got adjacent pulses=%b, expected 0", adjPulse);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mReset();
    test_reset();
    test_full_sequence();
    test_bad_key();
    test_idle_relock();
    test_held_strobe();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
